// File: rtl/aux_uart_boot_loader.sv
// UART boot loader: receives 8N1 bytes on aux_uart_rx and packs them little-endian into
// 32-bit memory writes while holding the MCU in reset. Boot ends after an idle timeout.
module aux_uart_boot_loader #(
  parameter int CLK_FREQUENCY = 50000000,
  parameter int BAUD_RATE     = 115200,
  parameter int ADDR_WIDTH    = 14,
  parameter int IDLE_TIMEOUT  = 5000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  aux_uart_rx,
  output logic                  boot_active,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [7:0]            rx_byte,
  output logic                  rx_valid,
  output logic                  framing_error
);

  localparam int DIV = CLK_FREQUENCY / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam int TW  = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [CW-1:0]         CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]         CNT_HALF   = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0]         CNT_LAST   = CW'(DIV - 1);
  localparam logic [TW-1:0]         TIMER_ZERO = TW'(0);
  localparam logic [TW-1:0]         TIMER_ONE  = TW'(1);
  // One cycle early so the flush strobe is visible while the timer shows IDLE_TIMEOUT-1.
  localparam logic [TW-1:0]         TIMER_FIRE = TW'(IDLE_TIMEOUT - 2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  logic            rx_meta_r;
  logic            rxs_r;
  rx_state_t       state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [2:0]      bit_r, bit_s;
  logic [7:0]      shift_r, shift_s;
  logic            byte_done_s;
  logic            frame_err_s;

  logic [1:0]      idx_r;
  logic [TW-1:0]   timer_r;
  logic            armed_r;
  logic            ending_r;
  logic            load_s;
  logic            timeout_s;

  // Two-flop synchronizer for the asynchronous receive line.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
    end else begin
      rx_meta_r <= aux_uart_rx;
      rxs_r     <= rx_meta_r;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
    end
  end

  // Receiver next-state logic: mid-bit sampling, LSB first.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r + CNT_ONE;
    bit_s       = bit_r;
    shift_s     = shift_r;
    byte_done_s = 1'b0;
    frame_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s = CNT_ZERO;
        if (!rxs_r) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == CNT_HALF) begin
          cnt_s = CNT_ZERO;
          bit_s = 3'd0;
          if (!rxs_r) begin
            state_s = ST_DATA;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s   = CNT_ZERO;
          shift_s = {rxs_r, shift_r[7:1]};
          bit_s   = bit_r + 3'd1;
          if (bit_r == 3'd7) begin
            state_s = ST_STOP;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s = CNT_ZERO;
          if (rxs_r) begin
            byte_done_s = 1'b1;
            state_s     = ST_IDLE;
          end else begin
            frame_err_s = 1'b1;
            state_s     = ST_BREAK;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        cnt_s = CNT_ZERO;
        if (rxs_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BREAK;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // A byte completing on the timeout cycle suppresses the timeout (byte wins).
  always_comb begin
    load_s    = byte_done_s && boot_active && !ending_r;
    timeout_s = armed_r && boot_active && !ending_r && !byte_done_s &&
                (timer_r == TIMER_FIRE);
  end

  // Byte reporting, word assembly, memory writes and boot timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_byte       <= 8'h00;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= ADDR_ZERO;
      mem_wdata     <= 32'h0000_0000;
      idx_r         <= 2'd0;
      timer_r       <= TIMER_ZERO;
      armed_r       <= 1'b0;
      ending_r      <= 1'b0;
      boot_active   <= 1'b1;
    end else begin
      rx_valid <= byte_done_s;
      mem_we   <= 1'b0;
      if (byte_done_s) begin
        rx_byte <= shift_r;
      end
      if (frame_err_s) begin
        framing_error <= 1'b1;
      end

      if (mem_we) begin
        mem_addr  <= mem_addr + ADDR_ONE;
        mem_wdata <= 32'h0000_0000;
        idx_r     <= 2'd0;
      end else if (load_s) begin
        mem_wdata[{idx_r, 3'b000} +: 8] <= shift_r;
        idx_r  <= idx_r + 2'd1;
        mem_we <= (idx_r == 2'd3);
      end else if (timeout_s) begin
        mem_we <= (idx_r != 2'd0);
      end

      if (byte_done_s) begin
        armed_r <= 1'b1;
        timer_r <= TIMER_ZERO;
      end else if (armed_r && boot_active && !ending_r) begin
        timer_r <= timer_r + TIMER_ONE;
      end

      if (timeout_s) begin
        ending_r <= 1'b1;
      end
      if (ending_r) begin
        boot_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aux_uart_boot_loader.sv
// Randomized bench for aux_uart_boot_loader: two instances (14-bit and 2-bit address)
// share one RX line; received bytes and writes are compared with a word-packing model.
module tb_aux_uart_boot_loader;

  localparam int DIV = 16;
  localparam int TO  = 1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;

  logic        boot_a, we_a, rxv_a, fe_a;
  logic [13:0] addr_a;
  logic [31:0] wdata_a;
  logic [7:0]  rxb_a;
  logic        boot_b, we_b, rxv_b, fe_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [7:0]  rxb_b;

  aux_uart_boot_loader #(.CLK_FREQUENCY(1600000), .BAUD_RATE(100000),
                         .ADDR_WIDTH(14), .IDLE_TIMEOUT(TO)) dut_a (
    .clk(clk), .reset(reset), .aux_uart_rx(rx), .boot_active(boot_a),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .rx_byte(rxb_a),
    .rx_valid(rxv_a), .framing_error(fe_a));

  aux_uart_boot_loader #(.CLK_FREQUENCY(1600000), .BAUD_RATE(100000),
                         .ADDR_WIDTH(2), .IDLE_TIMEOUT(TO)) dut_b (
    .clk(clk), .reset(reset), .aux_uart_rx(rx), .boot_active(boot_b),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .rx_byte(rxb_b),
    .rx_valid(rxv_b), .framing_error(fe_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observations since the last reset.
  logic [7:0]  rxv_q[$];
  logic [13:0] wa_addr[$];
  logic [31:0] wa_data[$];
  int          wa_cyc[$];
  logic [1:0]  wb_addr[$];
  logic [31:0] wb_data[$];
  int          rxv_b_cnt, last_rxv, fall_a, fall_b, we_late;
  logic        prev_a, prev_b;

  always @(negedge clk) begin
    if (reset) begin
      rxv_q.delete(); wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
      wb_addr.delete(); wb_data.delete();
      rxv_b_cnt <= 0; last_rxv <= 0; fall_a <= -1; fall_b <= -1; we_late <= 0;
      prev_a <= 1'b1; prev_b <= 1'b1;
    end else begin
      if (rxv_a) begin
        rxv_q.push_back(rxb_a);
        last_rxv <= cyc;
      end
      if (rxv_b) rxv_b_cnt <= rxv_b_cnt + 1;
      if (we_a) begin
        wa_addr.push_back(addr_a); wa_data.push_back(wdata_a); wa_cyc.push_back(cyc);
      end
      if (we_b) begin
        wb_addr.push_back(addr_b); wb_data.push_back(wdata_b);
      end
      if ((we_a && !boot_a) || (we_b && !boot_b)) we_late <= we_late + 1;
      if (prev_a && !boot_a) fall_a <= cyc;
      if (prev_b && !boot_b) fall_b <= cyc;
      prev_a <= boot_a;
      prev_b <= boot_b;
    end
  end

  logic [7:0] sent_q[$];

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    repeat (DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(posedge clk);
    end
    rx = stop_ok;
    repeat (DIV) @(posedge clk);
    rx = 1'b1;
    if (stop_ok) sent_q.push_back(b);
    repeat ($urandom_range(40, 4)) @(posedge clk);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    rx = 1'b1;
    sent_q.delete();
    repeat (3) @(posedge clk);
    reset = 1'b0;
    @(negedge clk);
    check({tag, "_boot"}, boot_a, 1'b1);
    check({tag, "_we"}, we_a, 1'b0);
    check({tag, "_addr"}, addr_a, 14'd0);
    check({tag, "_wdata"}, wdata_a, 32'h0);
    check({tag, "_rxbyte"}, rxb_a, 8'h00);
    check({tag, "_rxvalid"}, rxv_a, 1'b0);
    check({tag, "_ferr"}, fe_a, 1'b0);
  endtask

  // Model: good bytes packed four per word, little-endian, partial word zero-padded,
  // consecutive word addresses modulo the address space; boot ends TO cycles after last byte.
  task automatic verify(input string tag);
    logic [31:0] exp_w[$];
    logic [31:0] w;
    int n;
    repeat (TO + 20) @(posedge clk);
    @(negedge clk);
    n = sent_q.size();
    w = 32'h0;
    for (int i = 0; i < n; i++) begin
      w = w | (32'(sent_q[i]) << (8 * (i % 4)));
      if (i % 4 == 3) begin
        exp_w.push_back(w);
        w = 32'h0;
      end
    end
    if (n % 4 != 0) exp_w.push_back(w);

    check({tag, "_rxcount"}, rxv_q.size(), n);
    check({tag, "_rxcount_b"}, rxv_b_cnt, n);
    for (int i = 0; i < n && i < rxv_q.size(); i++) check({tag, "_rxbyte"}, rxv_q[i], sent_q[i]);
    if (n > 0) check({tag, "_rxbyte_b"}, rxb_b, sent_q[n-1]);
    check({tag, "_wcount_a"}, wa_addr.size(), exp_w.size());
    check({tag, "_wcount_b"}, wb_addr.size(), exp_w.size());
    for (int k = 0; k < exp_w.size() && k < wa_addr.size(); k++) begin
      check({tag, "_addr_a"}, wa_addr[k], k % 16384);
      check({tag, "_data_a"}, wa_data[k], exp_w[k]);
    end
    for (int k = 0; k < exp_w.size() && k < wb_addr.size(); k++) begin
      check({tag, "_addr_b"}, wb_addr[k], k % 4);
      check({tag, "_data_b"}, wb_data[k], exp_w[k]);
    end
    check({tag, "_boot_a"}, boot_a, 1'b0);
    check({tag, "_boot_b"}, boot_b, 1'b0);
    check({tag, "_fall_a"}, fall_a - last_rxv, TO);
    check({tag, "_fall_b"}, fall_b - last_rxv, TO);
    if (n % 4 != 0 && wa_cyc.size() > 0)
      check({tag, "_flush_time"}, wa_cyc[wa_cyc.size()-1] - last_rxv, TO - 1);
    check({tag, "_we_late"}, we_late, 0);
  endtask

  initial begin
    do_reset("rst0");
    repeat (1200) @(posedge clk);
    @(negedge clk);
    check("nobyte_boot", boot_a, 1'b1);
    check("nobyte_writes", wa_addr.size(), 0);

    send_byte(8'h13, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    verify("word1");

    send_byte(8'h5A, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("post_rxcount", rxv_q.size(), 5);
    check("post_rxbyte", rxb_a, 8'h5A);
    check("post_writes", wa_addr.size(), 1);
    check("post_we_late", we_late, 0);

    do_reset("rst1");
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
    verify("eight");

    do_reset("rst2");
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
    verify("flush");

    do_reset("rst3");
    rx = 1'b0;
    repeat (4) @(posedge clk);
    rx = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("glitch_rx", rxv_q.size(), 0);
    check("glitch_ferr", fe_a, 1'b0);
    send_byte(8'h55, 1'b0);
    @(negedge clk);
    check("badstop_ferr", fe_a, 1'b1);
    check("badstop_ferr_b", fe_b, 1'b1);
    check("badstop_rx", rxv_q.size(), 0);
    send_byte(8'h3C, 1'b1);
    verify("after_err");
    check("ferr_sticky", fe_a, 1'b1);

    do_reset("rst4");
    for (int i = 0; i < 20; i++) send_byte(8'($urandom_range(255, 0)), 1'b1);
    verify("wrap");

    do_reset("rst5");
    send_byte(8'($urandom_range(255, 0)), 1'b1);
    send_byte(8'($urandom_range(255, 0)), 1'b1);
    repeat (5) @(posedge clk);
    do_reset("midword");
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(255, 0)), 1'b1);
    verify("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
